// File: rtl/trigger_capture.sv
// Level/edge trigger with hysteresis, decimation and pre-trigger history.
// A completed capture is read back through a registered, trigger-relative port.
module trigger_capture #(
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 256,
  parameter int PRE_SAMPLES  = 64,
  parameter int DECIM_W      = 16,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_input,
  input  logic [DATA_W-1:0]        level,
  input  logic [DATA_W-1:0]        hyst,
  input  logic                     edge_sel,
  input  logic [DECIM_W-1:0]       decim,
  input  logic                     auto_en,
  input  logic                     arm,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     capture_done,
  output logic                     trig_forced,
  output logic [2:0]               trig_state
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(DEPTH - PRE_SAMPLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [AW-1:0]    PRE_OFF   = AW'(PRE_SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       trig_addr_q, trig_addr_d;
  logic                below_q, below_d;
  logic                above_q, above_d;
  logic                forced_q, forced_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                tick, we, arm_ok, edge_hit, timeout;
  logic [DATA_W:0]     hi_sum;
  logic [DATA_W-1:0]   lo, hi;
  logic [AW-1:0]       rd_idx;

  // Saturating band edges so level near either rail never wraps.
  assign hi_sum = {1'b0, level} + {1'b0, hyst};
  assign hi     = hi_sum[DATA_W] ? {DATA_W{1'b1}} : hi_sum[DATA_W-1:0];
  assign lo     = (level >= hyst) ? (level - hyst) : '0;

  assign tick     = (dcnt_q == decim);
  assign arm_ok   = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign edge_hit = edge_sel ? (above_q && (data_input <= level))
                             : (below_q && (data_input >= level));
  assign timeout  = auto_en && (cnt_q >= TO_LAST);

  always_comb begin
    state_d     = state_q;
    dcnt_d      = tick ? '0 : dcnt_q + 1'b1;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    below_d     = below_q;
    above_d     = above_q;
    forced_d    = forced_q;
    we          = 1'b0;

    if (arm_ok) begin
      state_d  = S_PRE;
      dcnt_d   = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      below_d  = 1'b0;
      above_d  = 1'b0;
      forced_d = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        S_PRE: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          below_d  = below_q | (data_input <= lo);
          above_d  = above_q | (data_input >= hi);
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ARMED: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          below_d  = below_q | (data_input <= lo);
          above_d  = above_q | (data_input >= hi);
          // A real edge on the timeout tick wins over the forced trigger.
          if (edge_hit) begin
            trig_addr_d = wr_ptr_q;
            below_d     = 1'b0;
            above_d     = 1'b0;
            forced_d    = 1'b0;
            cnt_d       = '0;
            state_d     = S_POST;
          end else if (timeout) begin
            trig_addr_d = wr_ptr_q;
            forced_d    = 1'b1;
            cnt_d       = '0;
            state_d     = S_POST;
          end else if (cnt_q < TO_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_POST: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (cnt_q == POST_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      below_q     <= 1'b0;
      above_q     <= 1'b0;
      forced_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      below_q     <= below_d;
      above_q     <= above_d;
      forced_q    <= forced_d;
    end
  end

  // Capture memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= data_input;
  end

  assign rd_idx = trig_addr_q - PRE_OFF + rd_addr;

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_idx];
  end

  assign rd_data      = rd_data_q;
  assign busy         = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign capture_done = (state_q == S_DONE);
  assign trig_forced  = forced_q;
  assign trig_state   = state_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: edges, hysteresis, decimation, auto trigger,
// saturation, reset and re-arm, with hand-computed expectations.
module tb_trigger_capture;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 256;
  localparam int PRE    = 64;
  localparam int DECW   = 16;
  localparam int AUTO   = 4096;

  localparam int IDLE = 0, PRET = 1, ARMD = 2, POST = 3, DONE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_input, level, hyst;
  logic              edge_sel, auto_en, arm;
  logic [DECW-1:0]   decim;
  logic [7:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy, capture_done, trig_forced;
  logic [2:0]        trig_state;

  int n_vec = 0;
  int n_err = 0;

  trigger_capture #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_SAMPLES(PRE), .DECIM_W(DECW), .AUTO_TIMEOUT(AUTO)
  ) dut (
    .clk(clk), .rst(rst), .data_input(data_input), .level(level), .hyst(hyst),
    .edge_sel(edge_sel), .decim(decim), .auto_en(auto_en), .arm(arm), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .capture_done(capture_done),
    .trig_forced(trig_forced), .trig_state(trig_state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int st, input int bz, input int dn);
    chk({tag, "/state"}, 32'(trig_state), 32'(st));
    chk({tag, "/busy"},  32'(busy), 32'(bz));
    chk({tag, "/done"},  32'(capture_done), 32'(dn));
  endtask

  task automatic feed(input int v, input int n = 1);
    data_input = DATA_W'(v);
    step(n);
  endtask

  task automatic rd(input string tag, input int a, input int exp);
    rd_addr = 8'(a);
    step();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_arm(input int v);
    data_input = DATA_W'(v);
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data_input = '0; level = '0; hyst = '0; edge_sel = 1'b0;
    auto_en = 1'b0; arm = 1'b0; decim = '0; rd_addr = '0;
    step(2);
    chk_st("reset", IDLE, 0, 0);
    chk("reset/forced", 32'(trig_forced), 0);
    chk("reset/rd_data", 32'(rd_data), 0);
    rst = 1'b0;

    // Rising edge on a ramp, no decimation
    level = 12'd1054; hyst = 12'd8;
    do_arm(940);
    chk_st("rise/arm", PRET, 1, 0);
    for (int v = 941; v <= 1053; v++) feed(v);
    chk_st("rise/pre_edge", ARMD, 1, 0);
    feed(1054);
    chk_st("rise/trig", POST, 1, 0);
    for (int v = 1055; v <= 1244; v++) feed(v);
    chk_st("rise/post190", POST, 1, 0);
    feed(1245);
    chk_st("rise/done191", DONE, 0, 1);
    chk("rise/forced", 32'(trig_forced), 0);
    rd("rise/rd64", 64, 1054);
    rd("rise/rd0", 0, 990);
    rd("rise/rd255", 255, 1245);

    // Falling edge with noise inside the band; re-arm from DONE
    edge_sel = 1'b1;
    do_arm(1054);
    chk_st("fall/rearm", PRET, 1, 0);
    for (int i = 0; i < 104; i++) feed(1049 + (i * 7) % 11);
    chk_st("fall/noise", ARMD, 1, 0);
    feed(900);
    chk_st("fall/drop_no_above", ARMD, 1, 0);
    feed(1070);
    feed(1060);
    chk_st("fall/above_set", ARMD, 1, 0);
    feed(1050);
    chk_st("fall/trig", POST, 1, 0);
    feed(800, 190);
    chk_st("fall/post190", POST, 1, 0);
    feed(800);
    chk_st("fall/done", DONE, 0, 1);
    rd("fall/rd64", 64, 1050);
    rd("fall/rd63", 63, 1060);
    rd("fall/rd62", 62, 1070);
    rd("fall/rd61", 61, 900);

    // Decimation by 4 on a counter input
    edge_sel = 1'b0; decim = 16'd3; level = 12'd260; hyst = 12'd8;
    do_arm(0);
    chk_st("dec/arm", PRET, 1, 0);
    for (int n = 1; n <= 259; n++) feed(n);
    chk_st("dec/pre_edge", ARMD, 1, 0);
    feed(260);
    chk_st("dec/trig", POST, 1, 0);
    for (int n = 261; n <= 1023; n++) feed(n);
    chk_st("dec/post", POST, 1, 0);
    feed(1024);
    chk_st("dec/done", DONE, 0, 1);
    rd("dec/rd0_first", 0, 4);
    rd("dec/rd1", 1, 8);
    rd("dec/rd64", 64, 260);
    rd("dec/rd255", 255, 1024);
    decim = '0;

    // Low-rail saturation (lo = 0) and arm ignored while ARMED
    level = 12'd2; hyst = 12'd10;
    do_arm(100);
    feed(100, 64);
    chk_st("satlo/armed", ARMD, 1, 0);
    feed(1);
    feed(5);
    chk_st("satlo/no_wrap", ARMD, 1, 0);
    do_arm(5);
    chk_st("satlo/arm_ignored", ARMD, 1, 0);
    feed(0);
    feed(3);
    chk_st("satlo/trig", POST, 1, 0);
    feed(7, 191);
    chk_st("satlo/done", DONE, 0, 1);
    rd("satlo/rd64", 64, 3);
    rd("satlo/rd63", 63, 0);
    rd("satlo/rd62", 62, 5);

    // High-rail saturation (hi = 4095) then reset during POST
    level = 12'd4090; hyst = 12'd10; edge_sel = 1'b1;
    do_arm(4000);
    feed(4000, 64);
    chk_st("sathi/armed", ARMD, 1, 0);
    feed(3000);
    chk_st("sathi/no_wrap", ARMD, 1, 0);
    feed(4095);
    feed(4000);
    chk_st("sathi/trig", POST, 1, 0);
    feed(4000, 10);
    rst = 1'b1;
    step();
    chk_st("rst_post", IDLE, 0, 0);
    chk("rst_post/forced", 32'(trig_forced), 0);
    chk("rst_post/rd_data", 32'(rd_data), 0);
    rst = 1'b0;

    // Forced trigger on ARMED tick AUTO
    level = 12'd2000; hyst = 12'd8; edge_sel = 1'b0; auto_en = 1'b1;
    do_arm(0);
    feed(0, PRE + AUTO - 1);
    chk_st("auto/before", ARMD, 1, 0);
    chk("auto/before_forced", 32'(trig_forced), 0);
    feed(0);
    chk_st("auto/fire", POST, 1, 0);
    chk("auto/forced", 32'(trig_forced), 1);
    feed(0, 191);
    chk_st("auto/done", DONE, 0, 1);
    chk("auto/done_forced", 32'(trig_forced), 1);

    // Real edge coincident with timeout is not forced
    do_arm(0);
    chk("both/arm_clears_forced", 32'(trig_forced), 0);
    feed(0, PRE + AUTO - 1);
    chk_st("both/before", ARMD, 1, 0);
    feed(2000);
    chk_st("both/trig", POST, 1, 0);
    chk("both/forced", 32'(trig_forced), 0);
    feed(0, 191);
    chk_st("both/done", DONE, 0, 1);
    rd("both/rd64", 64, 2000);

    // No auto trigger: stays ARMED
    auto_en = 1'b0;
    do_arm(0);
    feed(0, PRE + AUTO + 200);
    chk_st("noauto/stay", ARMD, 1, 0);
    chk("noauto/forced", 32'(trig_forced), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
